// File: rtl/elevator_scheduler_if.sv
// Call/status bundle between the request source and the elevator scheduler.
// With ELEVATOR_ESTOP_EN defined, the bundle also carries the estop input.
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
);
    logic [NUM_FLOORS-1:0] req;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  direction;
    logic                  door;
    logic                  moving;
    logic [NUM_FLOORS-1:0] pending;
`ifdef ELEVATOR_ESTOP_EN
    logic                  estop;

    modport master (output req, estop,
                    input  current_floor, direction, door, moving, pending);
    modport slave  (input  req, estop,
                    output current_floor, direction, door, moving, pending);
`else
    modport master (output req,
                    input  current_floor, direction, door, moving, pending);
    modport slave  (input  req,
                    output current_floor, direction, door, moving, pending);
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-order scheduler for one elevator car, with floor travel and door dwell timing.
// Optional ELEVATOR_ESTOP_EN adds an estop input that freezes travel, departure and dwell.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    elevator_scheduler_if.slave bus
);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                state;
    logic [FLOOR_W-1:0]    floor_q;
    logic                  direction_q;
    logic                  door_q;
    logic                  moving_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [TW-1:0]         travel_cnt;
    logic [DW-1:0]         door_cnt;
    logic                  halt;

`ifdef ELEVATOR_ESTOP_EN
    assign halt = bus.estop;
`else
    assign halt = 1'b0;
`endif

    // True when any set bit of p lies strictly above (up=1) or below (up=0) floor f.
    function automatic logic any_beyond(input logic [NUM_FLOORS-1:0] p,
                                        input logic [FLOOR_W-1:0] f, input logic up);
        any_beyond = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if ((up && i > int'(f)) || (!up && i < int'(f)))
                any_beyond = any_beyond | p[i];
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        floor_mask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    logic [FLOOR_W-1:0]    step_floor;
    logic [NUM_FLOORS-1:0] captured;
    logic                  ahead_here, behind_here, ahead_next;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        step_floor  = direction_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        captured    = pending_q | bus.req;
        ahead_here  = any_beyond(pending_q, floor_q, direction_q);
        behind_here = any_beyond(pending_q, floor_q, !direction_q);
        ahead_next  = any_beyond(pending_q, step_floor, direction_q);
    end

    // NOTE: sequential state uses non-blocking assignments only; a later assignment to
    // pending_q in the same cycle overrides the default capture, which is how clear wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            floor_q     <= '0;
            direction_q <= 1'b1;
            door_q      <= 1'b0;
            moving_q    <= 1'b0;
            pending_q   <= '0;
            travel_cnt  <= '0;
            door_cnt    <= '0;
        end else begin
            pending_q <= captured;
            case (state)
                IDLE: begin
                    if (pending_q[floor_q]) begin
                        state     <= DOOR;
                        door_q    <= 1'b1;
                        door_cnt  <= '0;
                        pending_q <= captured & ~floor_mask(floor_q);
                    end else if (!halt && (ahead_here || behind_here)) begin
                        state      <= MOVE;
                        moving_q   <= 1'b1;
                        travel_cnt <= '0;
                        if (!ahead_here)
                            direction_q <= !direction_q;
                    end
                end
                MOVE: begin
                    if (!halt) begin
                        if (travel_cnt == TW'(TRAVEL_CYCLES - 1)) begin
                            travel_cnt <= '0;
                            floor_q    <= step_floor;
                            if (pending_q[step_floor]) begin
                                state     <= DOOR;
                                moving_q  <= 1'b0;
                                door_q    <= 1'b1;
                                door_cnt  <= '0;
                                pending_q <= captured & ~floor_mask(step_floor);
                            end else if (!ahead_next) begin
                                state    <= IDLE;
                                moving_q <= 1'b0;
                            end
                        end else begin
                            travel_cnt <= travel_cnt + TW'(1);
                        end
                    end
                end
                DOOR: begin
                    // Calls for the open floor are absorbed for the whole dwell.
                    pending_q <= captured & ~floor_mask(floor_q);
                    if (!halt) begin
                        if (door_cnt == DW'(DOOR_CYCLES - 1)) begin
                            state  <= IDLE;
                            door_q <= 1'b0;
                        end else begin
                            door_cnt <= door_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.current_floor = floor_q;
    assign bus.direction     = direction_q;
    assign bus.door          = door_q;
    assign bus.moving        = moving_q;
    assign bus.pending       = pending_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios plus random calls,
// compared every cycle against a countdown-based behavioural model of the car.
module tb_elevator_scheduler;
    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TRAVEL = 2;
    localparam int DWELL = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL),
                         .DOOR_CYCLES(DWELL)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: remaining-cycle countdowns instead of phases.
    int          m_floor;
    bit          m_dir;
    bit [NF-1:0] m_pend;
    int          m_door_left;
    int          m_travel_left;

    function automatic bit m_beyond(input int f, input bit up);
        for (int i = 0; i < NF; i++)
            if (m_pend[i] && ((up && i > f) || (!up && i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1'b1; m_pend = '0; m_door_left = 0; m_travel_left = 0;
    endtask

    task automatic model_step(input bit [NF-1:0] r, input bit stop);
        bit [NF-1:0] clr;
        clr = '0;
        if (m_door_left > 0) begin
            clr[m_floor] = 1'b1;
            if (!stop) m_door_left--;
        end else if (m_travel_left > 0) begin
            if (!stop) begin
                m_travel_left--;
                if (m_travel_left == 0) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        clr[m_floor] = 1'b1;
                        m_door_left = DWELL;
                    end else if (m_beyond(m_floor, m_dir)) begin
                        m_travel_left = TRAVEL;
                    end
                end
            end
        end else if (m_pend[m_floor]) begin
            clr[m_floor] = 1'b1;
            m_door_left = DWELL;
        end else if (!stop) begin
            if (m_beyond(m_floor, m_dir)) begin
                m_travel_left = TRAVEL;
            end else if (m_beyond(m_floor, !m_dir)) begin
                m_dir = !m_dir;
                m_travel_left = TRAVEL;
            end
        end
        m_pend = (m_pend | r) & ~clr;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".floor"},   32'(bus.current_floor), 32'(m_floor));
        check({tag, ".dir"},     32'(bus.direction),     32'(m_dir));
        check({tag, ".door"},    32'(bus.door),          32'(m_door_left > 0));
        check({tag, ".moving"},  32'(bus.moving),        32'(m_travel_left > 0));
        check({tag, ".pending"}, 32'(bus.pending),       32'(m_pend));
    endtask

    task automatic tick(input string tag, input logic [NF-1:0] r, input bit s);
        bus.req = r;
`ifdef ELEVATOR_ESTOP_EN
        bus.estop = s;
`endif
        @(posedge clk);
        model_step(r, s);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset(input int n);
        reset_n = 1'b0;
        bus.req = '0;
`ifdef ELEVATOR_ESTOP_EN
        bus.estop = 1'b0;
`endif
        repeat (n) @(posedge clk);
        model_reset();
        #1;
        check("reset.floor",   32'(bus.current_floor), 32'd0);
        check("reset.dir",     32'(bus.direction),     32'd1);
        check("reset.door",    32'(bus.door),          32'd0);
        check("reset.moving",  32'(bus.moving),        32'd0);
        check("reset.pending", 32'(bus.pending),       32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        int      n;
        int      door_cycles;
        bit      prev_door;
        int      stops[$];
        logic [NF-1:0] r;
        bit      s;

        // Reset held for two edges.
        apply_reset(2);

        // Call to floor 2 from floor 0.
        tick("t2.pulse", 4'b0100, 1'b0);
        check("t2.pend_set", 32'(bus.pending), 32'b0100);
        n = 0;
        while (bus.door !== 1'b1 && n < 20) begin
            tick("t2.travel", '0, 1'b0);
            n++;
        end
        check("t2.door_latency", 32'(n), 32'd5);
        check("t2.arrive_floor", 32'(bus.current_floor), 32'd2);
        repeat (3) tick("t2.dwell", '0, 1'b0);
        check("t2.door_closed", 32'(bus.door), 32'd0);
        check("t2.pend_clear",  32'(bus.pending), 32'd0);

        // Same-floor call at floor 0.
        apply_reset(1);
        tick("t3.req", 4'b0001, 1'b0);
        check("t3.door_early", 32'(bus.door), 32'd0);
        door_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick("t3.dwell", '0, 1'b0);
            if (bus.door === 1'b1) door_cycles++;
            check("t3.no_move", 32'(bus.moving), 32'd0);
        end
        check("t3.door_cycles", 32'(door_cycles), 32'd3);
        check("t3.floor", 32'(bus.current_floor), 32'd0);

        // Up-sweep from floor 1 with calls picked up on the way, then reversal.
        apply_reset(1);
        tick("t4.to1", 4'b0010, 1'b0);
        repeat (8) tick("t4.settle", '0, 1'b0);
        tick("t4.call3", 4'b1000, 1'b0);
        tick("t4.depart", '0, 1'b0);
        check("t4.moving", 32'(bus.moving), 32'd1);
        tick("t4.call02", 4'b0101, 1'b0);
        prev_door = bus.door;
        for (int i = 0; i < 40; i++) begin
            tick("t4.run", '0, 1'b0);
            if (bus.door === 1'b1 && !prev_door) stops.push_back(int'(bus.current_floor));
            prev_door = bus.door;
        end
        check("t4.n_stops", 32'(stops.size()), 32'd3);
        if (stops.size() == 3) begin
            check("t4.stop0", 32'(stops[0]), 32'd2);
            check("t4.stop1", 32'(stops[1]), 32'd3);
            check("t4.stop2", 32'(stops[2]), 32'd0);
        end
        check("t4.dir_down", 32'(bus.direction), 32'd0);

        // Held call for the open floor does not extend the dwell.
        apply_reset(1);
        r = 4'b0100;
        door_cycles = 0;
        prev_door = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick("t5.run", r, 1'b0);
            if (bus.door === 1'b1) door_cycles++;
            if (prev_door && bus.door !== 1'b1) begin
                check("t5.pend2_exit", 32'(bus.pending[2]), 32'd0);
                r = '0;
            end
            prev_door = bus.door;
        end
        check("t5.door_cycles", 32'(door_cycles), 32'd3);

        // Reset while travelling.
        apply_reset(1);
        tick("t6.call", 4'b1000, 1'b0);
        repeat (3) tick("t6.move", '0, 1'b0);
        check("t6.moving", 32'(bus.moving), 32'd1);
        apply_reset(1);
        tick("t6.after", '0, 1'b0);
        check("t6.idle", 32'(bus.moving), 32'd0);

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop for 5 cycles mid-travel delays arrival by exactly 5.
        apply_reset(1);
        tick("es.call", 4'b0010, 1'b0);
        tick("es.depart", '0, 1'b0);
        check("es.moving", 32'(bus.moving), 32'd1);
        n = 0;
        repeat (5) begin
            tick("es.hold", '0, 1'b1);
            n++;
            check("es.frozen", 32'(bus.current_floor), 32'd0);
        end
        while (bus.current_floor !== FW'(1) && n < 20) begin
            tick("es.resume", '0, 1'b0);
            n++;
        end
        check("es.arrival", 32'(n), 32'(TRAVEL + 5));
`endif

        // Random calls against the model.
        apply_reset(1);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(0, (1 << NF) - 1)) : '0;
`ifdef ELEVATOR_ESTOP_EN
            s = ($urandom_range(0, 9) == 0);
`else
            s = 1'b0;
`endif
            tick("rand", r, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
